result_to_ascii: RTL and testbench

RESULT_TO_ASCII -- requirements
Module: result_to_ascii

---
 rtl/result_to_ascii.sv | 180 ++++++++++++++++++
 tb/tb_result_to_ascii.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/result_to_ascii.sv
// ============================================================================
// result_to_ascii
// ----------------------------------------------------------------------------
// Renders a signed two's-complement result as an ASCII hex string, one
// character per output handshake: an optional '-', then the hex magnitude,
// most significant digit first, with leading zeros suppressed (zero -> "0").
// Digits 10-15 are emitted in lowercase.
//
// Optional feature (macro ASCII_TERM_EN):
//   defined   -> every string is followed by a '=' terminator, and only the
//                terminator carries out_last.
//   undefined -> the last digit carries out_last.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_data is offered
//   in_ready   out  block can accept a result (IDLE only)
//   in_data    in   DATA_W-bit signed result
//   out_valid  out  ascii_out holds a character
//   out_ready  in   sink accepts the character
//   ascii_out  out  ASCII character code
//   out_last   out  current character ends the string
//   busy       out  conversion in progress (equals out_valid)
// ============================================================================
module result_to_ascii #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        ascii_out,
    output logic              out_last,
    output logic              busy
);

    localparam int NIB   = DATA_W / 4;
    localparam int IDX_W = $clog2(NIB);
    localparam logic [DATA_W-1:0] ONE = 1;

`ifdef ASCII_TERM_EN
    typedef enum logic [1:0] {IDLE, SIGN, DIGIT, TERM} state_t;
`else
    typedef enum logic [1:0] {IDLE, SIGN, DIGIT} state_t;
`endif

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] mag;
    logic [IDX_W-1:0]  idx;

    logic [DATA_W-1:0] mag_in;
    logic [IDX_W-1:0]  lead_idx;
    logic [3:0]        cur_nib;
    logic              accept;
    logic              out_fire;

    assign accept   = in_valid && (state == IDLE);
    assign out_fire = out_valid && out_ready;

    // The magnitude is taken as an unsigned DATA_W-bit value, so the most
    // negative input negates onto itself and prints as e.g. "-8000".
    assign mag_in = in_data[DATA_W-1] ? (~in_data + ONE) : in_data;

    // Highest nonzero nibble of the incoming magnitude; a zero result leaves
    // index 0 so exactly one '0' digit is printed.
    always_comb begin
        lead_idx = '0;
        for (int i = 0; i < NIB; i++) begin
            if (mag_in[i*4 +: 4] != 4'd0) begin
                lead_idx = i[IDX_W-1:0];
            end
        end
    end

    // Nibble currently pointed at by the digit index.
    always_comb begin
        cur_nib = 4'd0;
        for (int i = 0; i < NIB; i++) begin
            if (idx == i[IDX_W-1:0]) begin
                cur_nib = mag[i*4 +: 4];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers: captured on acceptance, index walks down on each
    // digit handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag <= '0;
            idx <= '0;
        end else if (accept) begin
            mag <= mag_in;
            idx <= lead_idx;
        end else if (state == DIGIT && out_fire && idx != '0) begin
            idx <= idx - 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = in_data[DATA_W-1] ? SIGN : DIGIT;
                end
            end
            SIGN: begin
                if (out_ready) begin
                    state_next = DIGIT;
                end
            end
            DIGIT: begin
                if (out_ready && idx == '0) begin
`ifdef ASCII_TERM_EN
                    state_next = TERM;
`else
                    state_next = IDLE;
`endif
                end
            end
`ifdef ASCII_TERM_EN
            TERM: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Outputs are pure functions of registered state, so they hold stable
    // while the sink stalls.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state != IDLE);
        busy      = (state != IDLE);
        ascii_out = 8'd0;
        out_last  = 1'b0;
        case (state)
            SIGN: ascii_out = 8'd45;
            DIGIT: begin
                if (cur_nib < 4'd10) begin
                    ascii_out = 8'd48 + {4'd0, cur_nib};
                end else begin
                    ascii_out = 8'd87 + {4'd0, cur_nib};
                end
`ifndef ASCII_TERM_EN
                out_last = (idx == '0);
`endif
            end
`ifdef ASCII_TERM_EN
            TERM: begin
                ascii_out = 8'd61;
                out_last  = 1'b1;
            end
`endif
            default: begin
                ascii_out = 8'd0;
                out_last  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_result_to_ascii.sv
// ============================================================================
// tb_result_to_ascii
// ----------------------------------------------------------------------------
// Directed bench for result_to_ascii at DATA_W=16. Each vector lists the
// hand-derived character string; when ASCII_TERM_EN is defined the bench
// expects an extra '=' terminator carrying out_last instead of the last digit.
// ============================================================================
module tb_result_to_ascii;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  ascii_out;
    logic        out_last;
    logic        busy;

    int vectors_applied = 0;
    int miscompares     = 0;

    result_to_ascii #(.DATA_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ascii_out (ascii_out),
        .out_last  (out_last),
        .busy      (busy)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        vectors_applied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Offers one result and walks its string. chars holds up to six expected
    // characters, first character in the top byte. stall_at selects a
    // character to hold off for three cycles (-1: none). abort_after pulses
    // reset after that many handshakes (-1: none).
    task automatic applyStimulus(input logic [15:0] value, input logic [47:0] chars,
                                 input int n, input int stall_at, input int abort_after);
        int total;
        int waited;
        logic [7:0] exp_char;
        logic       exp_last;
`ifdef ASCII_TERM_EN
        total = n + 1;
`else
        total = n;
`endif
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_wait", {15'd0, in_ready}, 16'd1);
            return;
        end
        in_valid = 1'b1;
        in_data  = value;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 16'hDEAD;

        for (int k = 0; k < total; k++) begin
            if (abort_after >= 0 && k == abort_after) begin
                rst_n = 1'b0;
                #1;
                checkOutput("rst_out_valid", {15'd0, out_valid}, 16'd0);
                checkOutput("rst_busy",      {15'd0, busy},      16'd0);
                checkOutput("rst_ascii",     {8'd0, ascii_out},  16'd0);
                checkOutput("rst_in_ready",  {15'd0, in_ready},  16'd1);
                @(posedge clk); #1;
                rst_n = 1'b1;
                @(posedge clk); #1;
                checkOutput("post_rst_out_valid", {15'd0, out_valid}, 16'd0);
                checkOutput("post_rst_in_ready",  {15'd0, in_ready},  16'd1);
                return;
            end
            exp_char = (k < n) ? chars[47-8*k -: 8] : 8'd61;
            exp_last = (k == total - 1);
            checkOutput($sformatf("%h_valid%0d", value, k), {15'd0, out_valid}, 16'd1);
            checkOutput($sformatf("%h_char%0d", value, k), {8'd0, ascii_out}, {8'd0, exp_char});
            checkOutput($sformatf("%h_last%0d", value, k), {15'd0, out_last}, {15'd0, exp_last});
            checkOutput($sformatf("%h_busy%0d", value, k), {15'd0, busy}, 16'd1);
            checkOutput($sformatf("%h_inrdy%0d", value, k), {15'd0, in_ready}, 16'd0);
            if (k == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(posedge clk); #1;
                    checkOutput($sformatf("%h_hold_char%0d", value, s), {8'd0, ascii_out}, {8'd0, exp_char});
                    checkOutput($sformatf("%h_hold_last%0d", value, s), {15'd0, out_last}, {15'd0, exp_last});
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        checkOutput($sformatf("%h_idle_inrdy", value), {15'd0, in_ready}, 16'd1);
        checkOutput($sformatf("%h_idle_valid", value), {15'd0, out_valid}, 16'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'd0;
        out_ready = 1'b1;
        #1;
        checkOutput("reset_out_valid", {15'd0, out_valid}, 16'd0);
        checkOutput("reset_out_last",  {15'd0, out_last},  16'd0);
        checkOutput("reset_busy",      {15'd0, busy},      16'd0);
        checkOutput("reset_ascii",     {8'd0, ascii_out},  16'd0);
        checkOutput("reset_in_ready",  {15'd0, in_ready},  16'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        applyStimulus(16'h0000, {8'd48, 40'd0}, 1, -1, -1);
        applyStimulus(16'h00A3, {8'd97, 8'd51, 32'd0}, 2, -1, -1);
        applyStimulus(16'hFFFF, {8'd45, 8'd49, 32'd0}, 2, -1, -1);
        applyStimulus(16'h8000, {8'd45, 8'd56, 8'd48, 8'd48, 8'd48, 8'd0}, 5, -1, -1);
        applyStimulus(16'h1F0C, {8'd49, 8'd102, 8'd48, 8'd99, 16'd0}, 4, 1, -1);
        applyStimulus(16'h1234, {8'd49, 8'd50, 8'd51, 8'd52, 16'd0}, 4, -1, 2);
        applyStimulus(16'h0005, {8'd53, 40'd0}, 1, -1, -1);
        applyStimulus(16'hFFF6, {8'd45, 8'd97, 32'd0}, 2, -1, -1);
        applyStimulus(16'h7FFF, {8'd55, 8'd102, 8'd102, 8'd102, 16'd0}, 4, 3, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
